// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: size codes,
// FSM state encoding, port indices and the latched request payload.
package dmem_access_ctrl_pkg;

  localparam int unsigned MEM_AW = 6;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RMW_WR = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Request fields captured at grant; the word address lives in the mem_addr register
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Half needs addr[0]==0, word needs addr[1:0]==0; size 11 behaves as word
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      default: return (lane != 2'b00);
    endcase
  endfunction

  function automatic logic is_subword(input logic [1:0] size);
    return (size == SZ_B) || (size == SZ_H);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory
// word, and merges sub-word store data into a memory word (little-endian).
module dmem_access_ctrl_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and half of the memory word
  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  // Zero- or sign-extend the selected lane for loads
  always_comb begin
    o_load = i_word;
    case (i_size)
      SZ_B:    o_load = i_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    o_load = i_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  // Replace the addressed lane with right-aligned store data
  always_comb begin
    o_merged = i_word;
    case (i_size)
      SZ_B: begin
        case (i_lane)
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          2'd3:    o_merged[31:24] = i_wdata[7:0];
          default: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares a 64x32 word memory between a CPU load/store port (0) and a
// loader port (1); byte/half/word accesses, sub-word stores via RMW.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// skip memory and respond with rN_err; otherwise they are silently aligned).
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [1:0]        r0_size,
  input  logic              r0_uns,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [1:0]        r1_size,
  input  logic              r1_uns,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,
  output logic              r1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [5:0]        mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t              r_state;
  req_t                r_req;
  logic                r_port;
  logic                r_last;
  logic                r_mis;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic                r_err0;
  logic                r_err1;

  logic                w_idle;
  logic                w_any;
  logic                w_pick1;
  logic                w_sel_mis;
  req_t                w_sel;
  logic [MEM_AW-1:0]   w_sel_waddr;
  logic [DATA_W-1:0]   w_load;
  logic [DATA_W-1:0]   w_merged;

  // Arbitration: round-robin prefers the port not granted last; fixed mode favours port 0
  assign w_idle  = (r_state == ST_IDLE) && !rst;
  assign w_any   = r0_req || r1_req;
  assign w_pick1 = (PRIO_FIXED != 0) ? (r1_req && !r0_req)
                                     : (r1_req && (!r0_req || (r_last == PORT0)));

  // Grant is the arbiter decision in the sampling cycle, so it cannot be registered
  assign r0_gnt = w_idle && w_any && !w_pick1;
  assign r1_gnt = w_idle && w_any && w_pick1;

  // Mux the winning requester's fields
  always_comb begin
    w_sel       = '0;
    w_sel_waddr = '0;
    if (w_pick1) begin
      w_sel.we    = r1_we;
      w_sel.size  = r1_size;
      w_sel.uns   = r1_uns;
      w_sel.lane  = r1_addr[1:0];
      w_sel.wdata = r1_wdata;
      w_sel_waddr = MEM_AW'(r1_addr >> 2);
    end else begin
      w_sel.we    = r0_we;
      w_sel.size  = r0_size;
      w_sel.uns   = r0_uns;
      w_sel.lane  = r0_addr[1:0];
      w_sel.wdata = r0_wdata;
      w_sel_waddr = MEM_AW'(r0_addr >> 2);
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign w_sel_mis = is_misaligned(w_sel.size, w_sel.lane);
`else
  assign w_sel_mis = 1'b0;
`endif

  dmem_access_ctrl_lane_align u_lane_align (
    .i_size   (r_req.size),
    .i_uns    (r_req.uns),
    .i_lane   (r_req.lane),
    .i_word   (mem_rdata),
    .i_wdata  (r_req.wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // Access sequencer: IDLE -> ACCESS -> [RMW_WR] -> RESP -> IDLE, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_port      <= PORT0;
      r_last      <= PORT1;
      r_mis       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_port     <= w_pick1;
            r_last     <= w_pick1;
            r_req      <= w_sel;
            r_mis      <= w_sel_mis;
            r_mem_addr <= w_sel_waddr;
            if (!w_sel_mis) begin
              r_mem_read <= 1'b1;
              if (w_sel.we && !is_subword(w_sel.size)) begin
                r_mem_write <= 1'b1;
                r_mem_wdata <= w_sel.wdata;
              end
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_mis && r_req.we && is_subword(r_req.size)) begin
            // Merge against the word read this cycle; the merged word is what gets written
            r_mem_write <= 1'b1;
            r_mem_wdata <= w_merged;
            r_state     <= ST_RMW_WR;
          end else begin
            if (!r_mis && !r_req.we) begin
              if (r_port == PORT1) r_rdata1 <= w_load;
              else                 r_rdata0 <= w_load;
            end
            r_rvalid0 <= (r_port == PORT0);
            r_rvalid1 <= (r_port == PORT1);
            r_err0    <= r_mis && (r_port == PORT0);
            r_err1    <= r_mis && (r_port == PORT1);
            r_state   <= ST_RESP;
          end
        end
        ST_RMW_WR: begin
          r_rvalid0 <= (r_port == PORT0);
          r_rvalid1 <= (r_port == PORT1);
          r_state   <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign r0_rvalid = r_rvalid0;
  assign r1_rvalid = r_rvalid1;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
  assign r0_err    = r_err0;
  assign r1_err    = r_err1;
  assign mem_read  = r_mem_read;
  // A reset arriving during a write cycle must keep that write out of memory
  assign mem_write = r_mem_write && !rst;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: round-robin DUT plus a fixed-priority
// instance sharing the same request inputs, each with its own word memory.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r0_req, r0_we, r0_uns, r1_req, r1_we, r1_uns;
  logic [1:0]  r0_size, r1_size;
  logic [7:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;

  logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_read, mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        p_r0_gnt, p_r0_rvalid, p_r0_err, p_r1_gnt, p_r1_rvalid, p_r1_err;
  logic [31:0] p_r0_rdata, p_r1_rdata;
  logic        p_mem_read, p_mem_write;
  logic [5:0]  p_mem_addr;
  logic [31:0] p_mem_wdata, p_mem_rdata;

  logic [31:0] mem  [64];
  logic [31:0] memp [64];
  logic        pl_en;
  logic [5:0]  pl_addr;
  logic [31:0] pl_data;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr]  <= pl_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) if (p_mem_write) memp[p_mem_addr] <= p_mem_wdata;
  assign p_mem_rdata = memp[p_mem_addr];

  dmem_access_ctrl #(.ADDR_W(8), .PRIO_FIXED(0)) u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_uns(r0_uns), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_uns(r1_uns), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_access_ctrl #(.ADDR_W(8), .PRIO_FIXED(1)) u_dut_prio (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_uns(r0_uns), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(p_r0_gnt), .r0_rvalid(p_r0_rvalid), .r0_rdata(p_r0_rdata), .r0_err(p_r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_uns(r1_uns), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(p_r1_gnt), .r1_rvalid(p_r1_rvalid), .r1_rdata(p_r1_rdata), .r1_err(p_r1_err),
    .mem_read(p_mem_read), .mem_write(p_mem_write), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata)
  );

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One access: returns gnt->rvalid latency, gnt->mem_write latency (-1 if none)
  task automatic issue(input logic port, input logic we, input logic [1:0] size, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       output int lat, output int wr_lat, output logic saw_read,
                       output logic [31:0] rdata, output logic err);
    int gc;
    gc = -1; lat = -1; wr_lat = -1; saw_read = 1'b0; rdata = '0; err = 1'b0;
    @(negedge clk);
    if (port) begin
      r1_req = 1'b1; r1_we = we; r1_size = size; r1_uns = uns; r1_addr = addr; r1_wdata = wdata;
    end else begin
      r0_req = 1'b1; r0_we = we; r0_size = size; r0_uns = uns; r0_addr = addr; r0_wdata = wdata;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if (port ? r1_gnt : r0_gnt) begin gc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
    if (gc >= 0) begin
      for (int k = 0; k < 10; k++) begin
        if (mem_read) saw_read = 1'b1;
        if (mem_write && wr_lat < 0) wr_lat = cyc - gc;
        if (port ? r1_rvalid : r0_rvalid) begin
          lat = cyc - gc;
          rdata = port ? r1_rdata : r0_rdata;
          err = port ? r1_err : r0_err;
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, mem_read, mem_write} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, mem_read, mem_write});
    end
    n_checks++;
    if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h required 0/0", r0_rdata, r1_rdata);
    end
    n_checks++;
    if ({p_r0_rvalid, p_r1_rvalid, p_mem_read, p_mem_write} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_prio: got %b required 0000", {p_r0_rvalid, p_r1_rvalid, p_mem_read, p_mem_write});
    end
  endtask

  task automatic test_rr();
    int order[8];
    int gcyc[8];
    int ng, p0, p1;
    logic both;
    ng = 0; p0 = 0; p1 = 0; both = 1'b0;
    preload(6'd0, 32'h8081_7F11);
    do_reset();
    r0_req = 1'b1; r0_we = 1'b0; r0_size = SZ_W; r0_addr = 8'd0;
    r1_req = 1'b1; r1_we = 1'b0; r1_size = SZ_W; r1_addr = 8'd0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (r0_gnt && r1_gnt) both = 1'b1;
      if ((r0_gnt || r1_gnt) && ng < 8) begin order[ng] = r1_gnt ? 1 : 0; gcyc[ng] = cyc; ng++; end
      if (p_r0_gnt) p0++;
      if (p_r1_gnt) p1++;
      @(negedge clk);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (ng !== 7) begin n_fail++; $display("FAIL rr_count: got %0d required 7", ng); end
    n_checks++;
    if (ng < 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      n_fail++;
      $display("FAIL rr_order: got %0d%0d%0d%0d required 0101", order[0], order[1], order[2], order[3]);
    end
    n_checks++;
    if (ng < 2 || gcyc[1] - gcyc[0] != 3) begin
      n_fail++; $display("FAIL rr_spacing: got %0d required 3", gcyc[1] - gcyc[0]);
    end
    n_checks++;
    if (both !== 1'b0) begin n_fail++; $display("FAIL rr_dual_gnt: got 1 required 0"); end
    n_checks++;
    if (p0 !== 7 || p1 !== 0) begin n_fail++; $display("FAIL prio_gnts: got r0=%0d r1=%0d required 7/0", p0, p1); end
    n_checks++;
    if (r1_rdata !== 32'h8081_7F11) begin n_fail++; $display("FAIL rr_r1_rdata: got %h required 80817f11", r1_rdata); end
  endtask

  task automatic test_load_byte();
    int lat, wl; logic sr, er; logic [31:0] rd;
    issue(1'b0, 1'b0, SZ_B, 1'b0, 8'd1, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_a1: got %h required 0000007f", rd); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d required 2", lat); end
    issue(1'b0, 1'b0, SZ_B, 1'b0, 8'd0, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0011) begin n_fail++; $display("FAIL lb_a0: got %h required 00000011", rd); end
    issue(1'b0, 1'b0, SZ_B, 1'b0, 8'd3, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_a3_sext: got %h required ffffff80", rd); end
    issue(1'b0, 1'b0, SZ_B, 1'b1, 8'd3, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_a3: got %h required 00000080", rd); end
  endtask

  task automatic test_load_half();
    int lat, wl; logic sr, er; logic [31:0] rd;
    issue(1'b0, 1'b0, SZ_H, 1'b1, 8'd2, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== 32'h0000_8081) begin n_fail++; $display("FAIL lhu_a2: got %h required 00008081", rd); end
    issue(1'b0, 1'b0, SZ_H, 1'b0, 8'd2, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== 32'hFFFF_8081) begin n_fail++; $display("FAIL lh_a2: got %h required ffff8081", rd); end
    issue(1'b0, 1'b0, SZ_W, 1'b0, 8'd0, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== 32'h8081_7F11) begin n_fail++; $display("FAIL lw_a0: got %h required 80817f11", rd); end
    n_checks++;
    if (lat !== 2 || wl !== -1 || sr !== 1'b1) begin
      n_fail++; $display("FAIL lw_timing: got lat=%0d wr=%0d rd=%b required 2/-1/1", lat, wl, sr);
    end
  endtask

  task automatic test_store();
    int lat, wl; logic sr, er; logic [31:0] rd;
    preload(6'd1, 32'h1122_3344);
    issue(1'b1, 1'b1, SZ_B, 1'b0, 8'd5, 32'hFFFF_FFAB, lat, wl, sr, rd, er);
    n_checks++;
    if (mem[1] !== 32'h1122_AB44) begin n_fail++; $display("FAIL sb_word: got %h required 1122ab44", mem[1]); end
    n_checks++;
    if (wl !== 2 || lat !== 3) begin n_fail++; $display("FAIL sb_timing: got wr=%0d lat=%0d required 2/3", wl, lat); end
    n_checks++;
    if (r1_rdata !== 32'h8081_7F11) begin n_fail++; $display("FAIL sb_rdata_held: got %h required 80817f11", r1_rdata); end
    issue(1'b0, 1'b1, SZ_H, 1'b0, 8'd6, 32'h0000_BEEF, lat, wl, sr, rd, er);
    n_checks++;
    if (mem[1] !== 32'hBEEF_AB44 || lat !== 3) begin
      n_fail++; $display("FAIL sh_word: got %h lat=%0d required beefab44/3", mem[1], lat);
    end
    issue(1'b1, 1'b1, SZ_W, 1'b0, 8'd8, 32'hDEAD_BEEF, lat, wl, sr, rd, er);
    n_checks++;
    if (mem[2] !== 32'hDEAD_BEEF || wl !== 1 || lat !== 2) begin
      n_fail++; $display("FAIL sw_word: got %h wr=%0d lat=%0d required deadbeef/1/2", mem[2], wl, lat);
    end
  endtask

  task automatic test_misaligned();
    int lat, wl; logic sr, er; logic [31:0] rd;
    logic [31:0] exp_rd1, exp_rd2; logic exp_err, exp_sr;
`ifdef MISALIGN_TRAP_EN
    exp_rd1 = 32'h8081_7F11; exp_rd2 = 32'h8081_7F11; exp_err = 1'b1; exp_sr = 1'b0;
`else
    exp_rd1 = 32'hFFFF_8081; exp_rd2 = 32'hBEEF_AB44; exp_err = 1'b0; exp_sr = 1'b1;
`endif
    issue(1'b0, 1'b0, SZ_H, 1'b0, 8'd3, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== exp_rd1 || er !== exp_err) begin
      n_fail++; $display("FAIL mis_lh_a3: got %h err=%b required %h/%b", rd, er, exp_rd1, exp_err);
    end
    issue(1'b0, 1'b0, SZ_W, 1'b0, 8'd6, 32'h0, lat, wl, sr, rd, er);
    n_checks++;
    if (rd !== exp_rd2 || er !== exp_err) begin
      n_fail++; $display("FAIL mis_lw_a6: got %h err=%b required %h/%b", rd, er, exp_rd2, exp_err);
    end
    n_checks++;
    if (sr !== exp_sr || lat !== 2) begin
      n_fail++; $display("FAIL mis_lw_read: got rd=%b lat=%0d required %b/2", sr, lat, exp_sr);
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic got, bad;
    got = 1'b0; bad = 1'b0;
    preload(6'd3, 32'h5566_7788);
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b1; r0_size = SZ_B; r0_uns = 1'b0; r0_addr = 8'd12; r0_wdata = 32'h99;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (r0_gnt) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (got !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_gnt: got 0 required 1"); end
    @(negedge clk);
    r0_req = 1'b0; r0_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rst_rmw_wr_phase: got %b required 1", mem_write); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_rmw_wr_gate: got %b required 0", mem_write); end
    @(negedge clk);
    n_checks++;
    if (mem[3] !== 32'h5566_7788) begin n_fail++; $display("FAIL rst_rmw_word: got %h required 55667788", mem[3]); end
    n_checks++;
    if ({r0_rvalid, r1_rvalid, r0_err, r1_err, mem_read, mem_write} !== 6'h0 || r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rmw_outputs: got %b %h %h required 000000 0 0",
               {r0_rvalid, r1_rvalid, r0_err, r1_err, mem_read, mem_write}, r0_rdata, r1_rdata);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_write || r0_rvalid || r1_rvalid) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0 || mem[3] !== 32'h5566_7788) begin
      n_fail++; $display("FAIL rst_rmw_after: got activity=%b word=%h required 0/55667788", bad, mem[3]);
    end
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    r0_req = 1'b0; r0_we = 1'b0; r0_size = SZ_W; r0_uns = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_size = SZ_W; r1_uns = 1'b0; r1_addr = '0; r1_wdata = '0;
    test_reset();
    test_rr();
    test_load_byte();
    test_load_half();
    test_store();
    test_misaligned();
    test_reset_mid_rmw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
